// File: rtl/phy_tx_multilane.sv
// phy_tx_multilane: multi-lane PHY transmitter. Words arrive on a valid/ready
// handshake, are striped round-robin over LANES lanes and serialised MSB-first
// at one bit per clock. All lanes reload together on a shared word counter;
// lanes with nothing to send transmit the COM idle word.
// Optional feature: define PHY_TX_SCRAMBLE_EN for per-lane LFSR scrambling of
// data words (idle words stay unscrambled).

// One lane: holding register, shift register and optional scrambler.
module phy_tx_lane #(
    parameter int          DATA_W = 32,
    parameter logic [7:0]  COM    = 8'hBC
) (
    input  logic              clk_32f,
    input  logic              reset_L,
    input  logic              run,
    input  logic              boundary,
    input  logic              wr,
    input  logic [DATA_W-1:0] data,
    output logic              hold_full,
    output logic              bit_out,
    output logic              active
);
    localparam logic [DATA_W-1:0] IDLE = {(DATA_W/8){COM}};

    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] sh;

    // Holding register: a write at a boundary refills it as the old word leaves.
    always_ff @(posedge clk_32f) begin
        if (!reset_L) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (wr) begin
            hold      <= data;
            hold_full <= 1'b1;
        end else if (boundary) begin
            hold_full <= 1'b0;
        end
    end

    // Shift register: load held word or idle at the boundary, otherwise shift left.
    always_ff @(posedge clk_32f) begin
        if (!reset_L) begin
            sh     <= '0;
            active <= 1'b0;
        end else if (boundary) begin
            sh     <= hold_full ? hold : IDLE;
            active <= hold_full;
        end else begin
            sh     <= {sh[DATA_W-2:0], 1'b0};
        end
    end

`ifdef PHY_TX_SCRAMBLE_EN
    logic [15:0] lfsr;

    // Scrambler x^16+x^5+x^4+x^3+1; reseeded whenever the lane goes idle.
    always_ff @(posedge clk_32f) begin
        if (!reset_L)
            lfsr <= 16'hFFFF;
        else if (boundary && !hold_full)
            lfsr <= 16'hFFFF;
        else if (run)
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[4] ^ lfsr[3] ^ lfsr[2]};
    end

    assign bit_out = run & (sh[DATA_W-1] ^ (active & lfsr[15]));
`else
    assign bit_out = run & sh[DATA_W-1];
`endif
endmodule

module phy_tx_multilane #(
    parameter int          DATA_W = 32,
    parameter int          LANES  = 2,
    parameter logic [7:0]  COM    = 8'hBC
) (
    input  logic              clk_32f,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic [LANES-1:0]  phy_tx_out,
    output logic [LANES-1:0]  lane_active
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam int PTR_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic {SYNC, RUN} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [PTR_W-1:0]  ptr;
    logic              boundary;
    logic              run;
    logic              xfer;
    logic              ptr_full;
    logic [LANES-1:0]  hold_full;
    logic [LANES-1:0]  wr;

    assign boundary = (cnt == CNT_W'(DATA_W - 1));
    assign xfer     = valid_in & ready_out;

    // Shared word counter keeps every lane in lockstep.
    always_ff @(posedge clk_32f) begin
        if (!reset_L || boundary)
            cnt <= '0;
        else
            cnt <= cnt + CNT_W'(1);
    end

    // Stripe pointer advances per accepted word; kept across idle gaps.
    always_ff @(posedge clk_32f) begin
        if (!reset_L)
            ptr <= '0;
        else if (xfer)
            ptr <= (ptr == PTR_W'(LANES - 1)) ? '0 : ptr + PTR_W'(1);
    end

    // FSM state register.
    always_ff @(posedge clk_32f) begin
        if (!reset_L)
            state <= SYNC;
        else
            state <= state_nxt;
    end

    // FSM next state: align to the first word boundary, then run until reset.
    always_comb begin
        state_nxt = state;
        if (state == SYNC && boundary)
            state_nxt = RUN;
    end

    // FSM outputs: accept when the target lane has room or is emptying now.
    always_comb begin
        run       = (state == RUN);
        ready_out = run & (~ptr_full | boundary);
    end

    // Holding-register status of the lane the pointer selects.
    always_comb begin
        ptr_full = 1'b0;
        for (int i = 0; i < LANES; i++)
            if (ptr == PTR_W'(i))
                ptr_full = hold_full[i];
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign wr[i] = xfer && (ptr == PTR_W'(i));

        phy_tx_lane #(.DATA_W(DATA_W), .COM(COM)) u_lane (
            .clk_32f   (clk_32f),
            .reset_L   (reset_L),
            .run       (run),
            .boundary  (boundary),
            .wr        (wr[i]),
            .data      (data_in),
            .hold_full (hold_full[i]),
            .bit_out   (phy_tx_out[i]),
            .active    (lane_active[i])
        );
    end
endmodule

// File: tb/tb_phy_tx_multilane.sv
// Bench for phy_tx_multilane: a 32-bit/2-lane instance and a 16-bit/4-lane
// instance share clock and reset. Accepted words are pushed to per-lane
// scoreboard queues tagged with the cycle their shifting should start; every
// cycle the serial bits, lane_active and ready_out are compared against them.
module tb_phy_tx_multilane;
`ifdef PHY_TX_SCRAMBLE_EN
    localparam bit SCR = 1'b1;
`else
    localparam bit SCR = 1'b0;
`endif

    typedef struct { int start; logic [31:0] w; } ent_t;
    typedef struct { int at;    logic [31:0] w; } offer_t;

    logic        clk_32f = 1'b0;
    logic        reset_L = 1'b0;
    logic        drv_valid = 1'b0;
    logic [31:0] drv_data = '0;
    logic        sel4 = 1'b0;
    logic        rdy2, rdy4;
    logic [1:0]  phy2, act2;
    logic [3:0]  phy4, act4;
    logic [7:0]  com_b = 8'hBC;

    always #5 clk_32f = ~clk_32f;

    phy_tx_multilane #(.DATA_W(32), .LANES(2)) u_dut (
        .clk_32f(clk_32f), .reset_L(reset_L), .data_in(drv_data),
        .valid_in(drv_valid & ~sel4), .ready_out(rdy2),
        .phy_tx_out(phy2), .lane_active(act2));

    phy_tx_multilane #(.DATA_W(16), .LANES(4)) u_dut4 (
        .clk_32f(clk_32f), .reset_L(reset_L), .data_in(drv_data[15:0]),
        .valid_in(drv_valid & sel4), .ready_out(rdy4),
        .phy_tx_out(phy4), .lane_active(act4));

    wire [8:0] obs = sel4 ? {rdy4, phy4, act4} : {rdy2, 2'b00, phy2, 2'b00, act2};

    ent_t        q [4][$];
    offer_t      offers [$];
    logic [15:0] lf [4];
    int          cyc, kidx, m_p, m_l, xfers;
    int          total = 0, bad = 0;
    logic        exp_ready;
    logic [8:0]  exp_obs;

    task automatic model_reset();
        cyc = 0; kidx = 0; xfers = 0;
        for (int i = 0; i < 4; i++) begin
            q[i].delete();
            lf[i] = 16'hFFFF;
        end
    endtask

    task automatic drive();
        if (offers.size() > 0 && cyc >= offers[0].at) begin
            drv_valid = 1'b1; drv_data = offers[0].w;
        end else begin
            drv_valid = 1'b0; drv_data = $urandom;
        end
    endtask

    // Expected outputs for the current cycle.
    task automatic model_expect();
        int ph, b, ptr;
        logic raw, full;
        logic [3:0] pv, av;
        pv = '0; av = '0; exp_ready = 1'b0;
        if (cyc >= m_p) begin
            ph = cyc % m_p; b = m_p - 1 - ph;
            for (int i = 0; i < m_l; i++) begin
                if (q[i].size() > 0 && q[i][0].start == cyc - ph) begin
                    raw = q[i][0].w[b]; av[i] = 1'b1;
                    if (SCR) raw = raw ^ lf[i][15];
                end else begin
                    raw = com_b[b % 8];
                end
                pv[i] = raw;
            end
            ptr = kidx % m_l; full = 1'b0;
            for (int j = 0; j < q[ptr].size(); j++)
                if (q[ptr][j].start > cyc) full = 1'b1;
            exp_ready = (ph == m_p - 1) || !full;
        end
        exp_obs = (m_l == 4) ? {exp_ready, pv, av} : {exp_ready, 2'b00, pv[1:0], 2'b00, av[1:0]};
    endtask

    // Scoreboard/model update at the rising edge ending the current cycle.
    task automatic model_edge();
        bit bnd, nxt;
        bnd = (cyc % m_p) == m_p - 1;
        for (int i = 0; i < m_l; i++)
            if (q[i].size() > 0 && q[i][0].start + m_p - 1 == cyc) void'(q[i].pop_front());
        if (drv_valid && exp_ready) begin
            q[kidx % m_l].push_back('{start: ((cyc + 1) / m_p + 1) * m_p, w: drv_data});
            kidx++; xfers++;
            void'(offers.pop_front());
        end
        for (int i = 0; i < m_l; i++) begin
            nxt = q[i].size() > 0 && q[i][0].start == cyc + 1;
            if (bnd && !nxt) lf[i] = 16'hFFFF;
            else if (cyc >= m_p) lf[i] = {lf[i][14:0], lf[i][15] ^ lf[i][4] ^ lf[i][3] ^ lf[i][2]};
        end
        cyc++;
    endtask

    task automatic apply_reset(input int n);
        reset_L = 1'b0; drv_valid = 1'b0;
        repeat (n) @(posedge clk_32f);
        #1 reset_L = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        logic [7:0] first;
        sel4 = 1'b0; m_p = 32; m_l = 2; offers.delete();
        reset_L = 1'b0; drv_valid = 1'b0;
        repeat (4) begin
            @(negedge clk_32f);
            total++;
            if (obs !== 9'h000) begin
                bad++; $display("FAIL reset_state got=%h want=%h", obs, 9'h000);
            end
            @(posedge clk_32f);
        end
        #1 reset_L = 1'b1;
        model_reset();
        first = '0;
        repeat (96) begin
            drive();
            @(negedge clk_32f); model_expect();
            if (cyc >= 32 && cyc < 40) first = {first[6:0], phy2[0]};
            total++;
            if (obs !== exp_obs) begin
                bad++; $display("FAIL sync cyc=%0d got=%h want=%h", cyc, obs, exp_obs);
            end
            @(posedge clk_32f); model_edge(); #1;
        end
        total++;
        if (first !== 8'hBC) begin
            bad++; $display("FAIL first_com_byte got=%h want=%h", first, 8'hBC);
        end
    endtask

    task automatic test_striping();
        sel4 = 1'b0; m_p = 32; m_l = 2; offers.delete();
        offers.push_back('{at: 32, w: 32'hDEADBEEF});
        offers.push_back('{at: 33, w: 32'h01234567});
        offers.push_back('{at: 34, w: 32'hC0FFEE11});
        apply_reset(4);
        repeat (132) begin
            drive();
            @(negedge clk_32f); model_expect();
            total++;
            if (obs !== exp_obs) begin
                bad++; $display("FAIL stripe cyc=%0d got=%h want=%h", cyc, obs, exp_obs);
            end
            if (cyc == 40 || cyc == 63) begin
                total++;
                if (rdy2 !== (cyc == 63)) begin
                    bad++; $display("FAIL backpressure cyc=%0d got=%b want=%b", cyc, rdy2, cyc == 63);
                end
            end
            @(posedge clk_32f); model_edge(); #1;
        end
    endtask

    task automatic test_back_to_back();
        int snap;
        sel4 = 1'b0; m_p = 32; m_l = 2; offers.delete();
        for (int i = 0; i < 24; i++)
            offers.push_back('{at: 32, w: 32'h10000000 + i * 32'h01010101});
        apply_reset(3);
        snap = 0;
        repeat (448) begin
            drive();
            @(negedge clk_32f); model_expect();
            total++;
            if (obs !== exp_obs) begin
                bad++; $display("FAIL stream cyc=%0d got=%h want=%h", cyc, obs, exp_obs);
            end
            if (cyc >= 64 && (cyc % 32) == 5) begin
                total++;
                if (act2 !== 2'b11) begin
                    bad++; $display("FAIL stream_active cyc=%0d got=%b want=11", cyc, act2);
                end
            end
            @(posedge clk_32f); model_edge(); #1;
            if (cyc % 32 == 0 && cyc >= 96 && cyc <= 384) begin
                total++;
                if (xfers - snap !== 2) begin
                    bad++; $display("FAIL stream_rate cyc=%0d got=%0d want=2", cyc, xfers - snap);
                end
            end
            if (cyc % 32 == 0) snap = xfers;
        end
    endtask

    task automatic test_reset_mid();
        sel4 = 1'b0; m_p = 32; m_l = 2; offers.delete();
        offers.push_back('{at: 32, w: 32'hDEADBEEF});
        offers.push_back('{at: 33, w: 32'h01234567});
        offers.push_back('{at: 64, w: 32'h55AA33CC});
        offers.push_back('{at: 65, w: 32'h0F0F0F0F});
        apply_reset(4);
        repeat (71) begin
            drive();
            if (cyc == 70) reset_L = 1'b0;
            @(negedge clk_32f); model_expect();
            total++;
            if (obs !== exp_obs) begin
                bad++; $display("FAIL pre_reset cyc=%0d got=%h want=%h", cyc, obs, exp_obs);
            end
            @(posedge clk_32f);
            if (reset_L) model_edge();
            #1;
        end
        drv_valid = 1'b0;
        @(negedge clk_32f);
        total++;
        if (obs !== 9'h000) begin
            bad++; $display("FAIL mid_reset got=%h want=%h", obs, 9'h000);
        end
        apply_reset(3);
        offers.delete();
        repeat (100) begin
            drive();
            @(negedge clk_32f); model_expect();
            total++;
            if (obs !== exp_obs) begin
                bad++; $display("FAIL resync cyc=%0d got=%h want=%h", cyc, obs, exp_obs);
            end
            @(posedge clk_32f); model_edge(); #1;
        end
    endtask

    task automatic test_scramble4();
        sel4 = 1'b1; m_p = 16; m_l = 4; offers.delete();
        offers.push_back('{at: 16, w: 32'h0000A5C3});
        offers.push_back('{at: 17, w: 32'h00001234});
        offers.push_back('{at: 18, w: 32'h0000FFFF});
        offers.push_back('{at: 19, w: 32'h00000001});
        offers.push_back('{at: 20, w: 32'h00008000});
        offers.push_back('{at: 20, w: 32'h00005A5A});
        apply_reset(4);
        repeat (96) begin
            drive();
            @(negedge clk_32f); model_expect();
            total++;
            if (obs !== exp_obs) begin
                bad++; $display("FAIL lanes4 cyc=%0d got=%h want=%h", cyc, obs, exp_obs);
            end
            if (cyc == 32) begin
                total++;
                if (act4 !== 4'hF) begin
                    bad++; $display("FAIL lanes4_active got=%b want=1111", act4);
                end
            end
            @(posedge clk_32f); model_edge(); #1;
        end
        sel4 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_striping();
        test_back_to_back();
        test_reset_mid();
        test_scramble4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
